// File: rtl/calc2_pkg.sv
// Shared types for the calc2 request issuer: command/response codes,
// tag type, issuer FSM states and the retirement record.
package calc2_pkg;

    localparam int NUM_TAGS = 4;

    typedef logic [1:0] tag_t;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_IDLE    = 2'd0,
        RESP_OK      = 2'd1,
        RESP_OVF     = 2'd2,
        RESP_INVALID = 2'd3
    } resp_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DATA2 = 1'b1
    } state_e;

    typedef struct packed {
        logic       vld;
        logic       timeout;
        tag_t       tag;
        logic [3:0] cmd;
    } retire_t;

    function automatic logic [2:0] popcnt(input logic [NUM_TAGS-1:0] m);
        logic [2:0] s;
        s = '0;
        for (int i = 0; i < NUM_TAGS; i++) s = s + 3'(m[i]);
        return s;
    endfunction

endpackage

// File: rtl/calc2_tag_tracker.sv
// Tag bookkeeping: busy mask, per-tag command store and timeout counters,
// lowest-free allocation and one-per-cycle retirement arbitration.
module calc2_tag_tracker
    import calc2_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic                c_clk,
    input  logic                reset,
    input  logic                alloc_en,
    input  logic [3:0]          alloc_cmd,
    input  logic [1:0]          dut_resp,
    input  tag_t                dut_tag,
    output logic [NUM_TAGS-1:0] free_mask,
    output tag_t                alloc_tag,
    output retire_t             retire,
    output logic                spurious,
    output logic [2:0]          busy_cnt
);

    logic [NUM_TAGS-1:0]         busy, busy_nxt, pend, ret_mask, alloc_mask;
    logic [NUM_TAGS-1:0][3:0]    cmd_q;
    logic [NUM_TAGS-1:0][CW-1:0] cnt_q;
    logic                        resp_hit;

    assign free_mask = ~busy;

    always_comb begin
        for (int i = 0; i < NUM_TAGS; i++)
            pend[i] = busy[i] && (cnt_q[i] == CW'(TIMEOUT));
    end

    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--)
            if (!busy[i]) alloc_tag = tag_t'(i);

        resp_hit = (dut_resp != 2'd0) && busy[dut_tag];
        spurious = (dut_resp != 2'd0) && !busy[dut_tag];

        // A DUT response always beats a pending timeout; timeouts wait their turn.
        retire = '0;
        if (resp_hit) begin
            retire.vld = 1'b1;
            retire.tag = dut_tag;
        end else begin
            for (int i = NUM_TAGS - 1; i >= 0; i--) begin
                if (pend[i]) begin
                    retire.vld     = 1'b1;
                    retire.timeout = 1'b1;
                    retire.tag     = tag_t'(i);
                end
            end
        end
        retire.cmd = retire.vld ? cmd_q[retire.tag] : 4'd0;

        ret_mask              = '0;
        ret_mask[retire.tag]  = retire.vld;
        alloc_mask            = '0;
        alloc_mask[alloc_tag] = alloc_en;
        busy_nxt              = (busy & ~ret_mask) | alloc_mask;
    end

    // The allocation edge counts as the first outstanding cycle, so a tag
    // stays busy for exactly TIMEOUT cycles before it is forcibly retired.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            busy_cnt <= '0;
            cmd_q    <= '0;
            cnt_q    <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= popcnt(busy_nxt);
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (alloc_mask[i]) begin
                    cmd_q[i] <= alloc_cmd;
                    cnt_q[i] <= CW'(1);
                end else if (busy[i] && cnt_q[i] != CW'(TIMEOUT)) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc2_req_issuer.sv
// Per-port calc2 request issuer: two-cycle request FSM, registered request
// and response outputs around the tag tracker.
module calc2_req_issuer
    import calc2_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cmd,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    output logic [1:0]  req_tag_out,
    input  logic [1:0]  dut_resp,
    input  logic [31:0] dut_data,
    input  logic [1:0]  dut_tag,
    output logic        rsp_valid,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_tag,
    output logic [3:0]  rsp_cmd,
    output logic        rsp_timeout,
    output logic        spurious_err,
    output logic [2:0]  busy_cnt
);

    state_e              state_q;
    logic [31:0]         op2_q;
    logic [NUM_TAGS-1:0] free_mask;
    tag_t                alloc_tag;
    retire_t             retire;
    logic                spurious, xfer;

    // Gated by reset so the port reads not-ready while reset is held.
    assign in_ready = reset && (state_q == ST_IDLE) && (|free_mask);
    assign xfer     = in_valid && in_ready;

    calc2_tag_tracker #(.TIMEOUT(TIMEOUT), .CW(CW)) u_trk (
        .c_clk     (c_clk),
        .reset     (reset),
        .alloc_en  (xfer),
        .alloc_cmd (in_cmd),
        .dut_resp  (dut_resp),
        .dut_tag   (dut_tag),
        .free_mask (free_mask),
        .alloc_tag (alloc_tag),
        .retire    (retire),
        .spurious  (spurious),
        .busy_cnt  (busy_cnt)
    );

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            op2_q        <= '0;
            req_cmd_out  <= '0;
            req_data_out <= '0;
            req_tag_out  <= '0;
            rsp_valid    <= 1'b0;
            rsp_resp     <= '0;
            rsp_data     <= '0;
            rsp_tag      <= '0;
            rsp_cmd      <= '0;
            rsp_timeout  <= 1'b0;
            spurious_err <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (xfer) begin
                        req_cmd_out  <= in_cmd;
                        req_tag_out  <= alloc_tag;
                        req_data_out <= in_op1;
                        op2_q        <= in_op2;
                        state_q      <= ST_DATA2;
                    end else begin
                        req_cmd_out  <= '0;
                        req_tag_out  <= '0;
                        req_data_out <= '0;
                    end
                end
                default: begin
                    req_cmd_out  <= '0;
                    req_tag_out  <= '0;
                    req_data_out <= op2_q;
                    state_q      <= ST_IDLE;
                end
            endcase

            rsp_valid    <= retire.vld;
            rsp_timeout  <= retire.vld && retire.timeout;
            rsp_resp     <= (retire.vld && !retire.timeout) ? dut_resp : 2'd0;
            rsp_data     <= (retire.vld && !retire.timeout) ? dut_data : 32'd0;
            rsp_tag      <= retire.vld ? retire.tag : 2'd0;
            rsp_cmd      <= retire.cmd;
            spurious_err <= spurious_err || spurious;
        end
    end

endmodule
